// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the 2-input gate BIST checker.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Truth tables indexed by {a,b}: bit0=00, bit1=01, bit2=10, bit3=11
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

  // Sweep order is a plain up-count from VEC_FIRST to VEC_LAST
  localparam logic [1:0] VEC_FIRST = 2'b00;
  localparam logic [1:0] VEC_LAST  = 2'b11;

endpackage

// File: rtl/gate_bist_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module gate_bist_sat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/gate_bist_checker.sv
// Sweeps all four input vectors into a 2-input gate, samples after a settle
// window, and compares against TRUTH_TABLE; reports mismatch count and first failure.
module gate_bist_checker
  import gate_bist_pkg::*;
#(
  parameter logic [3:0]  TRUTH_TABLE   = TT_AND,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned PASSES        = 1,
  parameter int unsigned ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       first_fail_vec,
  output logic             first_fail_valid
);

  localparam int unsigned ST_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int unsigned SW_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [ST_W-1:0] SETTLE_LAST = ST_W'(SETTLE_CYCLES);
  localparam logic [SW_W-1:0] SWEEP_LAST  = SW_W'(PASSES - 1);

  state_t           state, state_next;
  logic [1:0]       vec_idx;
  logic [ST_W-1:0]  settle_cnt;
  logic [SW_W-1:0]  sweep_cnt;
  logic             run_start;
  logic             sample;
  logic             last_sample;
  logic             mismatch;

  always_comb begin
    state_next  = state;
    run_start   = 1'b0;
    sample      = 1'b0;
    last_sample = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = RUN;
          run_start  = 1'b1;
        end
      end
      RUN: begin
        sample      = (settle_cnt == SETTLE_LAST);
        last_sample = sample && (vec_idx == VEC_LAST) && (sweep_cnt == SWEEP_LAST);
        if (last_sample) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // dut_y only matters on sample edges, so an unknown gate output cannot leak into status
  assign mismatch = sample && (dut_y != TRUTH_TABLE[vec_idx]);

  // vec_idx wraps 11->00 on the final sample, which leaves the gate inputs at 0 in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      vec_idx          <= VEC_FIRST;
      settle_cnt       <= '0;
      sweep_cnt        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      state <= state_next;
      if (run_start) begin
        vec_idx          <= VEC_FIRST;
        settle_cnt       <= '0;
        sweep_cnt        <= '0;
        first_fail_vec   <= '0;
        first_fail_valid <= 1'b0;
      end else if (state == RUN) begin
        if (sample) begin
          settle_cnt <= '0;
          vec_idx    <= vec_idx + 2'd1;
          if (vec_idx == VEC_LAST) begin
            sweep_cnt <= (sweep_cnt == SWEEP_LAST) ? '0 : sweep_cnt + 1'b1;
          end
        end else begin
          settle_cnt <= settle_cnt + 1'b1;
        end
        if (mismatch && !first_fail_valid) begin
          first_fail_vec   <= vec_idx;
          first_fail_valid <= 1'b1;
        end
      end
    end
  end

  gate_bist_sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (run_start),
    .inc   (mismatch),
    .count (err_count)
  );

  assign dut_a = vec_idx[1];
  assign dut_b = vec_idx[0];
  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign pass  = (state == DONE) && (err_count == '0);

endmodule

// File: tb/tb_gate_bist_checker.sv
// Randomised bench for gate_bist_checker: three parameterisations, each driven by a
// behavioural gate and compared against an arithmetic model of sweep results and timing.
module tb_gate_bist_checker;
  import gate_bist_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_w   [3];
  logic       start_w [3];
  logic       a_w     [3];
  logic       b_w     [3];
  logic       y_w     [3];
  logic       busy_w  [3];
  logic       done_w  [3];
  logic       pass_w  [3];
  logic       ffv_w   [3];
  logic [1:0] ffvec_w [3];
  logic [3:0] gate_tt [3];
  logic [3:0] err0, err1;
  logic       err2;

  int vectors     = 0;
  int miscompares = 0;

  always_comb begin
    for (int i = 0; i < 3; i++) y_w[i] = gate_tt[i][{a_w[i], b_w[i]}];
  end

  gate_bist_checker u_and (
    .clk(clk), .rst(rst_w[0]), .start(start_w[0]), .dut_a(a_w[0]), .dut_b(b_w[0]),
    .dut_y(y_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .err_count(err0), .first_fail_vec(ffvec_w[0]), .first_fail_valid(ffv_w[0])
  );

  gate_bist_checker #(
    .TRUTH_TABLE(TT_OR), .SETTLE_CYCLES(0), .PASSES(2)
  ) u_or (
    .clk(clk), .rst(rst_w[1]), .start(start_w[1]), .dut_a(a_w[1]), .dut_b(b_w[1]),
    .dut_y(y_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .err_count(err1), .first_fail_vec(ffvec_w[1]), .first_fail_valid(ffv_w[1])
  );

  gate_bist_checker #(
    .ERR_W(1), .PASSES(2)
  ) u_sat (
    .clk(clk), .rst(rst_w[2]), .start(start_w[2]), .dut_a(a_w[2]), .dut_b(b_w[2]),
    .dut_y(y_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
    .err_count(err2), .first_fail_vec(ffvec_w[2]), .first_fail_valid(ffv_w[2])
  );

  function automatic int cfg_settle(input int i);
    return (i == 1) ? 0 : 2;
  endfunction

  function automatic int cfg_passes(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int cfg_errw(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic logic [3:0] cfg_tt(input int i);
    return (i == 1) ? 4'b1110 : 4'b1000;
  endfunction

  function automatic logic [31:0] get_err(input int i);
    case (i)
      0:       return {28'd0, err0};
      1:       return {28'd0, err1};
      default: return {31'd0, err2};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset(input int i);
    check("rst_busy",  32'(busy_w[i]), 0);
    check("rst_done",  32'(done_w[i]), 0);
    check("rst_pass",  32'(pass_w[i]), 0);
    check("rst_err",   get_err(i), 0);
    check("rst_ffv",   32'(ffv_w[i]), 0);
    check("rst_ffvec", 32'(ffvec_w[i]), 0);
    check("rst_ab",    32'({a_w[i], b_w[i]}), 0);
  endtask

  // Expected results follow directly from counting truth-table disagreements
  task automatic run_check(input int i, input logic [3:0] g, input bit noisy);
    int s, p, lat, per, total, emax, exp_err, exp_ff, n;
    bit exp_v;
    logic [3:0] tt;
    s = cfg_settle(i);
    p = cfg_passes(i);
    tt = cfg_tt(i);
    gate_tt[i] = g;
    per = 0; exp_ff = 0; exp_v = 0;
    for (int v = 0; v < 4; v++) begin
      if (g[v] != tt[v]) begin
        per++;
        if (!exp_v) begin
          exp_v  = 1;
          exp_ff = v;
        end
      end
    end
    total   = per * p;
    emax    = (1 << cfg_errw(i)) - 1;
    exp_err = (total > emax) ? emax : total;
    lat     = 4 * p * (s + 1) + 1;

    @(negedge clk) start_w[i] = 1'b1;
    @(negedge clk) start_w[i] = 1'b0;
    n = 1;
    check("start_busy", 32'(busy_w[i]), 1);
    check("start_done", 32'(done_w[i]), 0);
    check("start_err",  get_err(i), 0);
    check("start_ffv",  32'(ffv_w[i]), 0);
    while (!done_w[i] && n < lat + 5) begin
      check("vec_seq", 32'({a_w[i], b_w[i]}), 32'(((n - 1) / (s + 1)) % 4));
      start_w[i] = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      n++;
    end
    start_w[i] = 1'b0;
    check("latency",  32'(n), 32'(lat));
    check("done",     32'(done_w[i]), 1);
    check("busy_off", 32'(busy_w[i]), 0);
    check("pass",     32'(pass_w[i]), 32'(exp_err == 0));
    check("err",      get_err(i), 32'(exp_err));
    check("ffv",      32'(ffv_w[i]), 32'(exp_v));
    check("ffvec",    32'(ffvec_w[i]), 32'(exp_ff));
    check("ab_done",  32'({a_w[i], b_w[i]}), 0);
    repeat (3) @(negedge clk);
    check("hold_done", 32'(done_w[i]), 1);
    check("hold_err",  get_err(i), 32'(exp_err));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_w[i]   = 1'b1;
      start_w[i] = 1'b0;
      gate_tt[i] = 4'b1000;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) check_reset(i);
    for (int i = 0; i < 3; i++) rst_w[i] = 1'b0;

    run_check(0, 4'b1000, 0);   // good AND
    run_check(0, 4'b0000, 0);   // stuck-at-0
    run_check(0, 4'b1111, 0);   // stuck-at-1
    run_check(0, 4'b1000, 0);   // restart with good AND
    run_check(1, 4'b1110, 0);   // good OR, two sweeps
    run_check(1, 4'b1000, 0);   // AND against OR table
    run_check(2, 4'b0111, 1);   // NAND, 1-bit saturation, start noise

    // reset in the middle of a run
    gate_tt[0] = 4'b0000;
    @(negedge clk) start_w[0] = 1'b1;
    @(negedge clk) start_w[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_w[0] = 1'b1;
    @(negedge clk) rst_w[0] = 1'b0;
    check_reset(0);
    run_check(0, 4'b1000, 0);

    for (int r = 0; r < 12; r++) begin
      run_check(int'($urandom_range(0, 2)), 4'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
